// File: rtl/sp_ram_bist_pkg.sv
// Shared types and constants for the single-port RAM march BIST.
package sp_ram_bist_pkg;

  localparam int ERR_CNT_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_W0,
    ST_R0W1_RD,
    ST_R0W1_WR,
    ST_R1,
    ST_DRAIN,
    ST_DONE
  } bist_state_e;

  // March element data polarity: 0 = background pattern P, 1 = ~P
  localparam logic W0_INV = 1'b0;
  localparam logic R0_INV = 1'b0;
  localparam logic W1_INV = 1'b1;
  localparam logic R1_INV = 1'b1;

endpackage

// File: rtl/sp_ram_bist_ctrl_if.sv
// Single-port RAM access port (en/addr/wdata/we/be/bypass_en/rdata).
interface sp_ram_bist_ctrl_if #(
  parameter int ADDR_WIDTH = 15,
  parameter int DATA_WIDTH = 32
);
  logic                    en;
  logic [ADDR_WIDTH-1:0]   addr;
  logic [DATA_WIDTH-1:0]   wdata;
  logic                    we;
  logic [DATA_WIDTH/8-1:0] be;
  logic                    bypass_en;
  logic [DATA_WIDTH-1:0]   rdata;

  modport master (output en, addr, wdata, we, be, bypass_en, input rdata);
  modport slave  (input en, addr, wdata, we, be, bypass_en, output rdata);
endinterface

// File: rtl/sp_ram_bist_cmp.sv
// Read-data checker: one-deep expected/address pipeline, comparator,
// first-fail address capture and saturating mismatch counter.
module sp_ram_bist_cmp import sp_ram_bist_pkg::*; #(
  parameter int ADDR_WIDTH = 15,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rstn_i,
  input  logic                  clear_i,
  input  logic                  issue_rd_i,
  input  logic [DATA_WIDTH-1:0] exp_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] rdata_i,
  output logic                  fail_o,
  output logic [ADDR_WIDTH-1:0] fail_addr_o,
  output logic [ERR_CNT_W-1:0]  err_cnt_o
);

  logic                  chk_q;
  logic [DATA_WIDTH-1:0] exp_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  mism;

  // Read data lands one cycle after the read was issued
  assign mism = chk_q && (rdata_i != exp_q);

  // Pipeline the read context and accumulate mismatch status
  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      chk_q       <= 1'b0;
      exp_q       <= '0;
      addr_q      <= '0;
      fail_o      <= 1'b0;
      fail_addr_o <= '0;
      err_cnt_o   <= '0;
    end else begin
      chk_q  <= issue_rd_i;
      exp_q  <= exp_i;
      addr_q <= addr_i;
      if (clear_i) begin
        fail_o      <= 1'b0;
        fail_addr_o <= '0;
        err_cnt_o   <= '0;
      end else if (mism) begin
        fail_o <= 1'b1;
        if (!fail_o) fail_addr_o <= addr_q;
        if (err_cnt_o != '1) err_cnt_o <= err_cnt_o + ERR_CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/sp_ram_bist_ctrl.sv
// March BIST initiator: W0 up, R0W1 up, R1 down over the whole RAM.
// RAM port signals are decoded straight from state/counter so each access
// is presented in the same cycle as the state that issues it.
module sp_ram_bist_ctrl import sp_ram_bist_pkg::*; #(
  parameter int RAM_SIZE   = 32768,
  parameter int ADDR_WIDTH = $clog2(RAM_SIZE),
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rstn_i,
  input  logic                  start_i,
  input  logic [DATA_WIDTH-1:0] pattern_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  fail_o,
  output logic [ADDR_WIDTH-1:0] fail_addr_o,
  output logic [ERR_CNT_W-1:0]  err_cnt_o,
  sp_ram_bist_ctrl_if.master    ram
);

  localparam int BYTES   = DATA_WIDTH / 8;
  localparam int OFFS_W  = $clog2(BYTES);
  localparam int WORD_W  = ADDR_WIDTH - OFFS_W;
  localparam int N_WORDS = RAM_SIZE / BYTES;
  localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(N_WORDS - 1);

  bist_state_e           state;
  logic [WORD_W-1:0]     wcnt;
  logic [DATA_WIDTH-1:0] pat;
  logic                  accept;
  logic                  issue_rd;
  logic [DATA_WIDTH-1:0] exp_data;
  logic [ADDR_WIDTH-1:0] byte_addr;

  logic                  en_c, we_c;
  logic [DATA_WIDTH-1:0] wdata_c;

  assign accept    = start_i && (state == ST_IDLE || state == ST_DONE);
  assign issue_rd  = (state == ST_R0W1_RD) || (state == ST_R1);
  assign byte_addr = ADDR_WIDTH'(wcnt) << OFFS_W;
  assign exp_data  = (state == ST_R1) ? pat ^ {DATA_WIDTH{R1_INV}}
                                      : pat ^ {DATA_WIDTH{R0_INV}};

  // Sequencer: march elements, word counter, pattern and status flags
  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      state  <= ST_IDLE;
      wcnt   <= '0;
      pat    <= '0;
      busy_o <= 1'b0;
      done_o <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: if (start_i) begin
          pat    <= pattern_i;
          wcnt   <= '0;
          busy_o <= 1'b1;
          done_o <= 1'b0;
          state  <= ST_W0;
        end
        ST_W0: if (wcnt == LAST_WORD) begin
          wcnt  <= '0;
          state <= ST_R0W1_RD;
        end else begin
          wcnt <= wcnt + WORD_W'(1);
        end
        ST_R0W1_RD: state <= ST_R0W1_WR;
        // Last write leaves the counter at N-1, the start of the down sweep
        ST_R0W1_WR: if (wcnt == LAST_WORD) begin
          state <= ST_R1;
        end else begin
          wcnt  <= wcnt + WORD_W'(1);
          state <= ST_R0W1_RD;
        end
        ST_R1: if (wcnt == '0) state <= ST_DRAIN;
               else            wcnt  <= wcnt - WORD_W'(1);
        ST_DRAIN: begin
          busy_o <= 1'b0;
          done_o <= 1'b1;
          state  <= ST_DONE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // RAM access decode from the current state
  always_comb begin
    en_c    = 1'b0;
    we_c    = 1'b0;
    wdata_c = '0;
    case (state)
      ST_W0:      begin en_c = 1'b1; we_c = 1'b1; wdata_c = pat ^ {DATA_WIDTH{W0_INV}}; end
      ST_R0W1_RD: en_c = 1'b1;
      ST_R0W1_WR: begin en_c = 1'b1; we_c = 1'b1; wdata_c = pat ^ {DATA_WIDTH{W1_INV}}; end
      ST_R1:      en_c = 1'b1;
      default:    ;
    endcase
  end

  assign ram.en        = en_c;
  assign ram.we        = we_c;
  assign ram.wdata     = wdata_c;
  assign ram.addr      = en_c ? byte_addr : '0;
  assign ram.be        = {BYTES{en_c}};
  assign ram.bypass_en = 1'b0;

  sp_ram_bist_cmp #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_cmp (
    .clk         (clk),
    .rstn_i      (rstn_i),
    .clear_i     (accept),
    .issue_rd_i  (issue_rd),
    .exp_i       (exp_data),
    .addr_i      (byte_addr),
    .rdata_i     (ram.rdata),
    .fail_o      (fail_o),
    .fail_addr_o (fail_addr_o),
    .err_cnt_o   (err_cnt_o)
  );

endmodule
